// File: rtl/mem_port_arb_pkg.sv
// mem_port_arb_pkg: shared definitions for the two-port memory access controller.
//   - FSM state encoding (IDLE/ACC/RESP)
//   - access owner encoding (fetch port / data port)
//   - default address and data widths for the 256x16 memory
package mem_port_arb_pkg;

  localparam int DEF_AW = 8;
  localparam int DEF_DW = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner select for mem_port_arb.
// Ports:
//   i_req  - fetch request
//   d_req  - data request
//   dsat   - data streak has reached its limit
//   vld    - some port is requesting
//   own    - winning port (data wins ties unless the streak limit forces fetch)
module mem_arb_pick
  import mem_port_arb_pkg::*;
(
  input  logic   i_req,
  input  logic   d_req,
  input  logic   dsat,
  output logic   vld,
  output owner_t own
);

  assign vld = i_req | d_req;
  assign own = (d_req && !(dsat && i_req)) ? OWN_D : OWN_I;

endmodule

// File: rtl/mem_port_arb.sv
// mem_port_arb: two-port access controller in front of a 256x16 synchronous
// memory. Arbitrates between the read-only instruction-fetch port (i_*) and the
// load/store data port (d_*), drives the memory pins from registers and returns
// read data to the winning port with a one-cycle valid strobe.
//
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   i_req/i_addr -> i_gnt           - fetch request/address and grant pulse
//   i_rvalid/i_rdata                - fetch data return
//   d_req/d_we/d_addr/d_wdata       - data request (d_we=1 store, 0 load)
//   d_gnt, d_rvalid/d_rdata         - data grant pulse and load data return
//   d_err                           - protected-write error pulse
//   m_addr/m_wdata/m_we             - registered memory pins
//   m_rdata                         - memory read data (cycle after address)
//
// Build option: define MEM_ARB_WCHK_EN to block stores below PROT_TOP
// (granted, but not written, with d_err pulsed alongside d_gnt).
module mem_port_arb
  import mem_port_arb_pkg::*;
#(
  parameter int             AW          = DEF_AW,
  parameter int             DW          = DEF_DW,
  parameter int             MAX_DSTREAK = 3,
  parameter logic [AW-1:0]  PROT_TOP    = AW'(8'h40)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [DW-1:0] i_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,
  output logic          d_err,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  output logic          m_we,
  input  logic [DW-1:0] m_rdata
);

`ifdef MEM_ARB_WCHK_EN
  localparam bit WCHK_EN = 1'b1;
`else
  localparam bit WCHK_EN = 1'b0;
`endif

  localparam logic [2:0] MAXS = 3'(MAX_DSTREAK);

  state_t        state;
  owner_t        owner;
  logic          is_wr;
  logic [2:0]    streak;
  logic [DW-1:0] i_rdata_q;
  logic [DW-1:0] d_rdata_q;

  logic          pick_vld;
  owner_t        pick_own;
  logic          dsat;
  logic          prot_hit;

  function automatic logic [2:0] sat_inc(input logic [2:0] s);
    return (s >= MAXS) ? MAXS : s + 3'd1;
  endfunction

  assign dsat     = (streak == MAXS);
  assign prot_hit = WCHK_EN && d_we && (d_addr < PROT_TOP);

  mem_arb_pick u_pick (
    .i_req (i_req),
    .d_req (d_req),
    .dsat  (dsat),
    .vld   (pick_vld),
    .own   (pick_own)
  );

  // During the response cycle the owner sees the memory output directly; the
  // captured copy holds it afterwards so a port's data only moves on its own
  // valid strobe.
  assign i_rdata = i_rvalid ? m_rdata : i_rdata_q;
  assign d_rdata = d_rvalid ? m_rdata : d_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= OWN_I;
      is_wr     <= 1'b0;
      streak    <= 3'd0;
      m_addr    <= '0;
      m_wdata   <= '0;
      m_we      <= 1'b0;
      i_gnt     <= 1'b0;
      d_gnt     <= 1'b0;
      i_rvalid  <= 1'b0;
      d_rvalid  <= 1'b0;
      d_err     <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      i_gnt    <= 1'b0;
      d_gnt    <= 1'b0;
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      d_err    <= 1'b0;
      case (state)
        // Arbitration: latch the winner's access onto the memory pins
        IDLE: begin
          if (pick_vld) begin
            owner <= pick_own;
            state <= ACC;
            if (pick_own == OWN_D) begin
              m_addr  <= d_addr;
              m_wdata <= d_wdata;
              m_we    <= d_we && !prot_hit;
              is_wr   <= d_we;
              d_gnt   <= 1'b1;
              d_err   <= prot_hit;
              // Streak only counts data grants taken while a fetch waits
              streak  <= i_req ? sat_inc(streak) : 3'd0;
            end else begin
              m_addr  <= i_addr;
              m_we    <= 1'b0;
              is_wr   <= 1'b0;
              i_gnt   <= 1'b1;
              streak  <= 3'd0;
            end
          end
        end
        // Access: memory acts on this edge; writes are finished here
        ACC: begin
          m_we <= 1'b0;
          if (is_wr) begin
            state <= IDLE;
          end else begin
            state <= RESP;
            if (owner == OWN_D) d_rvalid <= 1'b1;
            else                i_rvalid <= 1'b1;
          end
        end
        // Response: capture read data for the owner only
        RESP: begin
          state <= IDLE;
          if (owner == OWN_D) d_rdata_q <= m_rdata;
          else                i_rdata_q <= m_rdata;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
